offset_move_scheduler: RTL

- Converts raw direction push-buttons into clean, frame-aligned move pulses for the character-offset datapath.
- The move pulses drive the 4-bit OffsetFlag bus, ordered {Right, Left, Down, Up}.
- Per-button functions: synchronise, debounce, detect press, latch request, auto-repeat while held.
- Requests are arbitrated round-robin; at most one move is issued per frame, on the frame_start boundary, so the displayed box never tears mid-frame.

---
 rtl/offset_move_scheduler_pkg.sv | 15 +
 rtl/offset_move_scheduler_button_debouncer.sv | 29 ++
 rtl/offset_move_scheduler.sv | 80 ++++++++
 3 files changed

// File: rtl/offset_move_scheduler_pkg.sv
// offset_move_scheduler_pkg: direction indices, FSM states and round-robin pick
package offset_move_scheduler_pkg;
    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;
    typedef enum logic [1:0] {S_IDLE, S_WAIT_FRAME, S_ISSUE} state_t;
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [7:0] dbl;
        logic [3:0] rot;
        dbl = {req, req} >> ptr;
        rot = dbl[3:0];
        return ptr + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
    endfunction
endpackage

// File: rtl/offset_move_scheduler_button_debouncer.sv
// button_debouncer: 2-FF synchroniser, stability counter and press pulse for one button
module button_debouncer #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          done;
    assign done = sync[1] != level && cnt == CW'(DEB_CYCLES - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            cnt   <= (sync[1] == level || done) ? '0 : cnt + 1'b1;
            level <= done ? ~level : level;
            rise  <= done && !level;
        end
    end
endmodule

// File: rtl/offset_move_scheduler.sv
// offset_move_scheduler: debounced buttons to frame-aligned one-hot move pulses
module offset_move_scheduler
    import offset_move_scheduler_pkg::*;
#(
    parameter int DEB_CYCLES   = 500000,
    parameter int PULSE_CYCLES = 4,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       frame_start,
    output logic [3:0] move_pulse,
    output logic [3:0] btn_level,
    output logic [3:0] pending,
    output logic       busy
);
    localparam int HW = REPEAT_DELAY > 0 ? $clog2(REPEAT_DELAY + 1) : 1;
    localparam int PW = PULSE_CYCLES > 1 ? $clog2(PULSE_CYCLES) : 1;
    logic [3:0]    rise, set, clr, cancel, pending_next;
    logic [1:0]    rr_ptr, grant;
    logic [PW-1:0] pcnt;
    logic          take;
    state_t        state;
    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic [HW-1:0] hold, inc;
        logic          rep;
        button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk(clk), .reset(reset), .raw(btn[i]), .level(btn_level[i]), .rise(rise[i])
        );
        assign inc    = hold + 1'b1;
        assign rep    = REPEAT_DELAY > 0 && btn_level[i] && frame_start && inc == HW'(REPEAT_DELAY);
        assign set[i] = rise[i] | rep;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                hold <= '0;
            else if (rise[i])
                hold <= '0;
            else if (REPEAT_DELAY > 0 && btn_level[i] && frame_start)
                hold <= rep ? HW'(REPEAT_DELAY - REPEAT_RATE) : inc;
        end
    end
    // Opposing directions held together suppress both requests outright
    assign cancel = {{2{btn_level[DIR_LEFT] & btn_level[DIR_RIGHT]}},
                     {2{btn_level[DIR_UP] & btn_level[DIR_DOWN]}}};
    assign take         = state == S_WAIT_FRAME && pending != '0 && frame_start;
    assign grant        = rr_pick(pending, rr_ptr);
    assign clr          = take ? 4'b0001 << grant : 4'b0000;
    assign pending_next = ((pending & ~clr) | set) & ~cancel;
    assign busy         = state != S_IDLE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            pcnt       <= '0;
            move_pulse <= '0;
            pending    <= '0;
        end else begin
            pending <= pending_next;
            if (state == S_IDLE) begin
                if (pending != '0)
                    state <= S_WAIT_FRAME;
            end else if (state == S_WAIT_FRAME) begin
                if (pending == '0)
                    state <= S_IDLE;
                else if (frame_start) begin
                    rr_ptr     <= grant + 2'd1;
                    move_pulse <= clr;
                    pcnt       <= '0;
                    state      <= S_ISSUE;
                end
            end else if (pcnt == PW'(PULSE_CYCLES - 1)) begin
                move_pulse <= '0;
                state      <= pending != '0 ? S_WAIT_FRAME : S_IDLE;
            end else
                pcnt <= pcnt + 1'b1;
        end
    end
endmodule
